// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_pkg
//  Brief    : Shared address map and status-word layout for the data memory
//             responder and its TX FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    // Memory-mapped registers; all other addresses hit the backed array
    localparam logic [15:0] TX_DATA_ADDR = 16'h8000;
    localparam logic [15:0] STATUS_ADDR  = 16'h8001;

    // Status word bit positions
    localparam int unsigned EMPTY_BIT = 0;
    localparam int unsigned FULL_BIT  = 1;
    localparam int unsigned CNT_LSB   = 2;
    localparam int unsigned CNT_MSB   = 4;
    localparam int unsigned FAULT_BIT = 15;

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/data_mem_responder_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tx_fifo
//  Brief    : Show-ahead FIFO feeding the TX consumer. Head entry is visible
//             combinationally; an explicit occupancy counter drives
//             full/empty so pointers can wrap freely.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [15:0]                   i_push_data,
    input  logic                          i_pop,
    output logic [15:0]                   o_head_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_full,
    output logic                          o_empty
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [15:0]        r_mem [0:FIFO_DEPTH-1];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push_accept;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign o_count = r_count;

    // A pop from empty is ignored; a push into a full FIFO is accepted only
    // when a pop frees the head slot in the same cycle.
    assign w_pop         = i_pop && !o_empty;
    assign w_push_accept = i_push && (!o_full || w_pop);

    // Head is shown directly from storage, forced to zero when empty so no
    // stale data leaks out.
    assign o_head_data = o_empty ? 16'h0000 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset because empty masks the output
    always_ff @(posedge clk) begin
        if (w_push_accept) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push_accept, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : tx_fifo
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Brief    : CPU data-memory slave: backed word array with read-first,
//             one-cycle reads, plus a memory-mapped TX FIFO and status word
//             with a sticky fault flag.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int RAM_SIZE   = 16,
    parameter int DEPTH_BITS = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RAM_SIZE-1:0] ram_address,
    input  logic                we,
    input  logic [15:0]         ram_out,
    output logic [15:0]         ram_in,
    output logic [15:0]         tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                fault
);

    localparam int c_CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int c_CNT_FIELD_W = CNT_MSB - CNT_LSB + 1;

    logic [15:0]           r_mem [0:(2**DEPTH_BITS)-1];
    logic [15:0]           r_ram_in;
    logic                  r_fault;

    logic [DEPTH_BITS-1:0] w_index;
    logic                  w_is_tx;
    logic                  w_is_status;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_overflow;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_CNT_W-1:0]    w_fifo_count;
    logic [15:0]           w_status;

    assign w_index     = ram_address[DEPTH_BITS-1:0];
    assign w_is_tx     = (ram_address == RAM_SIZE'(TX_DATA_ADDR));
    assign w_is_status = (ram_address == RAM_SIZE'(STATUS_ADDR));
    assign w_push      = we && w_is_tx;
    assign w_pop       = tx_valid && tx_ready;
    assign w_overflow  = w_push && w_fifo_full && !w_pop;

    tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (ram_out),
        .i_pop       (w_pop),
        .o_head_data (tx_data),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign tx_valid = !w_fifo_empty;
    assign ram_in   = r_ram_in;
    assign fault    = r_fault;

    // Status word built from pre-edge state
    always_comb begin
        w_status                    = 16'h0000;
        w_status[EMPTY_BIT]         = w_fifo_empty;
        w_status[FULL_BIT]          = w_fifo_full;
        w_status[CNT_MSB:CNT_LSB]   = c_CNT_FIELD_W'(w_fifo_count);
        w_status[FAULT_BIT]         = r_fault;
    end

    // Backed array write; register addresses never touch the array
    always_ff @(posedge clk) begin
        if (we && !w_is_tx && !w_is_status) begin
            r_mem[w_index] <= ram_out;
        end
    end

    // Registered read data; array read sees pre-write contents (read-first)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_in <= 16'h0000;
        end else if (w_is_status) begin
            r_ram_in <= w_status;
        end else if (w_is_tx) begin
            r_ram_in <= 16'h0000;
        end else begin
            r_ram_in <= r_mem[w_index];
        end
    end

    // Sticky fault: overflowing push or any write to the read-only status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_overflow || (we && w_is_status)) begin
            r_fault <= 1'b1;
        end
    end

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Brief    : Directed self-checking bench for data_mem_responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic [15:0] ram_address;
    logic        we;
    logic [15:0] ram_out;
    logic [15:0] ram_in;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        fault;

    int n_vec;
    int n_miss;

    data_mem_responder #(
        .RAM_SIZE   (16),
        .DEPTH_BITS (10),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ram_address (ram_address),
        .we          (we),
        .ram_out     (ram_out),
        .ram_in      (ram_in),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] addr, input logic w, input logic [15:0] d);
        ram_address = addr;
        we          = w;
        ram_out     = d;
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        rst         = 1'b1;
        tx_ready    = 1'b0;
        drive(16'h0000, 1'b0, 16'h0000);
        tick();
        tick();
        check("rst_ram_in",   ram_in,          16'h0000);
        check("rst_tx_valid", 16'(tx_valid),   16'h0000);
        check("rst_tx_data",  tx_data,         16'h0000);
        check("rst_fault",    16'(fault),      16'h0000);
        rst = 1'b0;

        // Array write, read back, and aliased read
        drive(16'h0005, 1'b1, 16'h1234);
        tick();
        drive(16'h0005, 1'b0, 16'h0000);
        tick();
        check("rd_addr5",     ram_in,          16'h1234);
        drive(16'h0405, 1'b0, 16'h0000);
        tick();
        check("rd_alias0405", ram_in,          16'h1234);

        // Read-during-write returns old contents
        drive(16'h0007, 1'b1, 16'h5555);
        tick();
        drive(16'h0007, 1'b1, 16'hAAAA);
        tick();
        check("rdw_old",      ram_in,          16'h5555);
        drive(16'h0007, 1'b0, 16'h0000);
        tick();
        check("rdw_new",      ram_in,          16'hAAAA);

        // Fill the FIFO with consumer stalled
        for (int i = 1; i <= 4; i++) begin
            drive(16'h8000, 1'b1, 16'(i));
            tick();
            if (i == 1) begin
                check("txaddr_rd0",  ram_in,        16'h0000);
                check("head_first",  tx_data,       16'h0001);
            end
        end
        drive(16'h8001, 1'b0, 16'h0000);
        tick();
        check("status_full",  ram_in,          16'h0012);
        check("no_fault_yet", 16'(fault),      16'h0000);
        drive(16'h8000, 1'b1, 16'h0005);
        tick();
        check("ovf_fault",    16'(fault),      16'h0001);
        drive(16'h8001, 1'b0, 16'h0000);
        tick();
        check("status_ovf",   ram_in,          16'h8012);

        // Drain: head order 1,2,3,4 then empty
        drive(16'h0000, 1'b0, 16'h0000);
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", 16'(tx_valid), 16'h0001);
            check("drain_data",  tx_data,       16'(i));
            tick();
        end
        check("drained_valid", 16'(tx_valid),  16'h0000);
        check("drained_data",  tx_data,        16'h0000);
        tx_ready = 1'b0;

        // Clear fault, refill, then push while popping at full
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_fault",   16'(fault),      16'h0000);
        for (int i = 1; i <= 4; i++) begin
            drive(16'h8000, 1'b1, 16'(i));
            tick();
        end
        tx_ready = 1'b1;
        drive(16'h8000, 1'b1, 16'h0009);
        check("full_pp_head", tx_data,         16'h0001);
        tick();
        tx_ready = 1'b0;
        check("full_pp_fault", 16'(fault),     16'h0000);
        drive(16'h8001, 1'b0, 16'h0000);
        tick();
        check("full_pp_status", ram_in,        16'h0012);
        drive(16'h0000, 1'b0, 16'h0000);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("full_pp_seq", tx_data, (i == 3) ? 16'h0009 : 16'(i + 2));
            tick();
        end
        check("full_pp_empty", 16'(tx_valid),  16'h0000);
        tx_ready = 1'b0;

        // Push and pop together with one entry held
        drive(16'h8000, 1'b1, 16'h00A1);
        tick();
        tx_ready = 1'b1;
        drive(16'h8000, 1'b1, 16'h00A2);
        tick();
        tx_ready = 1'b0;
        drive(16'h8001, 1'b0, 16'h0000);
        tick();
        check("one_pp_status", ram_in,         16'h0004);
        check("one_pp_head",   tx_data,        16'h00A2);

        // Write to STATUS only raises fault
        drive(16'h8001, 1'b1, 16'hFFFF);
        tick();
        check("stwr_fault",   16'(fault),      16'h0001);
        drive(16'h8001, 1'b0, 16'h0000);
        tick();
        check("stwr_status",  ram_in,          16'h8004);

        // Queue three, then reset mid-stream alongside a push
        drive(16'h8000, 1'b1, 16'h0011);
        tick();
        drive(16'h8000, 1'b1, 16'h0022);
        tick();
        rst = 1'b1;
        drive(16'h8000, 1'b1, 16'h0077);
        tick();
        rst = 1'b0;
        drive(16'h8001, 1'b0, 16'h0000);
        check("mid_rst_valid", 16'(tx_valid),  16'h0000);
        check("mid_rst_fault", 16'(fault),     16'h0000);
        check("mid_rst_data",  tx_data,        16'h0000);
        tick();
        check("mid_rst_status", ram_in,        16'h0001);
        drive(16'h0005, 1'b0, 16'h0000);
        tick();
        check("mem_kept",     ram_in,          16'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_data_mem_responder
`default_nettype wire
